// File: rtl/pipe_fetch_pc_if.sv
// Avalon-style instruction-memory read bus between the fetch stage and instruction memory.
interface pipe_fetch_pc_if;
    logic [31:0] instr_address;
    logic        instr_read;
    logic        instr_waitrequest;
    logic [31:0] instr_readdata;

    modport master (
        output instr_address,
        output instr_read,
        input  instr_waitrequest,
        input  instr_readdata
    );

    modport slave (
        input  instr_address,
        input  instr_read,
        output instr_waitrequest,
        output instr_readdata
    );
endinterface

// File: rtl/pipe_fetch_pc.sv
// Fetch front end: owns the PC, reads instruction memory, applies delayed redirects,
// presents fetched words to IF/ID through a one-entry stall buffer and halts at HALT_ADDR.
module pipe_fetch_pc #(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
    parameter logic [31:0] HALT_ADDR    = 32'h00000000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   PC_Write,
    input  logic                   redirect_valid,
    input  logic [31:0]            redirect_target,
    pipe_fetch_pc_if.master        mem,
    output logic [31:0]            IF_Reg_PC,
    output logic [31:0]            IF_Instr,
    output logic                   IF_Valid,
    output logic                   active
);
    localparam int unsigned XLEN = 32;

    localparam logic [1:0] S_RUN    = 2'd0;
    localparam logic [1:0] S_WAIT   = 2'd1;
    localparam logic [1:0] S_HALTED = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            pending_q, pending_d;
    logic [XLEN-1:0] target_q, target_d;
    logic            buf_valid_q, buf_valid_d;
    logic [XLEN-1:0] buf_pc_q, buf_pc_d;
    logic [XLEN-1:0] buf_instr_q, buf_instr_d;
    logic            valid_d, active_d;
    logic [XLEN-1:0] out_pc_d, out_instr_d;

    logic            read_c;
    logic            accept_c;
    logic            consume_c;
    logic            pend_eff_c;
    logic [XLEN-1:0] tgt_eff_c;
    logic [XLEN-1:0] next_pc_c;

    // Read request: a held request is never withdrawn; new requests need room downstream.
    always_comb begin
        read_c = 1'b0;
        case (state_q)
            S_RUN:   read_c = PC_Write & ~buf_valid_q;
            S_WAIT:  read_c = 1'b1;
            default: read_c = 1'b0;
        endcase
        if (reset) read_c = 1'b0;
    end

    // A redirect seen this cycle already counts, so a same-cycle accept is the delay slot.
    assign pend_eff_c = pending_q | redirect_valid;
    assign tgt_eff_c  = pending_q ? target_q : redirect_target;
    assign next_pc_c  = pend_eff_c ? tgt_eff_c : pc_q + XLEN'(4);
    assign accept_c   = read_c & ~mem.instr_waitrequest;
    assign consume_c  = PC_Write & IF_Valid;

    assign mem.instr_address = pc_q;
    assign mem.instr_read    = read_c;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        pending_d   = pend_eff_c;
        target_d    = tgt_eff_c;
        active_d    = active;
        valid_d     = IF_Valid;
        out_pc_d    = IF_Reg_PC;
        out_instr_d = IF_Instr;
        buf_valid_d = buf_valid_q;
        buf_pc_d    = buf_pc_q;
        buf_instr_d = buf_instr_q;

        case (state_q)
            S_RUN:   if (read_c && mem.instr_waitrequest) state_d = S_WAIT;
            S_WAIT:  if (accept_c) state_d = S_RUN;
            default: state_d = S_HALTED;
        endcase

        if (accept_c) begin
            pc_d      = next_pc_c;
            pending_d = 1'b0;
            if (next_pc_c == HALT_ADDR) begin
                state_d  = S_HALTED;
                active_d = 1'b0;
            end
        end

        // Output stage refills from the buffer first to keep program order.
        if (!IF_Valid || consume_c) begin
            if (buf_valid_q) begin
                valid_d     = 1'b1;
                out_pc_d    = buf_pc_q;
                out_instr_d = buf_instr_q;
                buf_valid_d = 1'b0;
            end else if (accept_c) begin
                valid_d     = 1'b1;
                out_pc_d    = pc_q;
                out_instr_d = mem.instr_readdata;
            end else begin
                valid_d = 1'b0;
            end
        end else if (accept_c) begin
            buf_valid_d = 1'b1;
            buf_pc_d    = pc_q;
            buf_instr_d = mem.instr_readdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_RUN;
            pc_q        <= RESET_VECTOR;
            pending_q   <= 1'b0;
            target_q    <= '0;
            buf_valid_q <= 1'b0;
            buf_pc_q    <= '0;
            buf_instr_q <= '0;
            IF_Valid    <= 1'b0;
            IF_Reg_PC   <= '0;
            IF_Instr    <= '0;
            active      <= 1'b1;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            pending_q   <= pending_d;
            target_q    <= target_d;
            buf_valid_q <= buf_valid_d;
            buf_pc_q    <= buf_pc_d;
            buf_instr_q <= buf_instr_d;
            IF_Valid    <= valid_d;
            IF_Reg_PC   <= out_pc_d;
            IF_Instr    <= out_instr_d;
            active      <= active_d;
        end
    end
endmodule
